// File: rtl/space_wire_pulse_handshake_tx_if.sv
// Event/handshake bundle for the pulse handshake transmitter.
// slave = the transmitter, master = whoever drives events and watches status.
interface space_wire_pulse_handshake_tx_if #(
  parameter int CNT_WIDTH = 4
);
  logic                 i_pulse;
  logic                 i_async_ack;
  logic                 i_clear_err;
  logic                 o_req;
  logic                 o_done;
  logic                 o_busy;
  logic [CNT_WIDTH-1:0] o_pending;
  logic                 o_overflow;
  logic                 o_timeout;

  modport slave (
    input  i_pulse, i_async_ack, i_clear_err,
    output o_req, o_done, o_busy, o_pending, o_overflow, o_timeout
  );

  modport master (
    output i_pulse, i_async_ack, i_clear_err,
    input  o_req, o_done, o_busy, o_pending, o_overflow, o_timeout
  );
endinterface

// File: rtl/space_wire_pulse_handshake_tx.sv
// Delivers local single-cycle event pulses to a foreign clock domain over a
// four-phase req/ack handshake, queuing bursts in a saturating counter.
module space_wire_pulse_handshake_tx #(
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  space_wire_pulse_handshake_tx_if.slave bus
);

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TLIM  = TO_EN ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [TW-1:0]        TO_LIM   = TW'(TLIM);
  localparam logic [CNT_WIDTH-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_q, req_d;
  logic                   done_q, done_d;
  logic [CNT_WIDTH-1:0]   pending_q, pending_d;
  logic                   overflow_q, overflow_d;
  logic                   timeout_q, timeout_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic                   ack_s;
  logic                   launch;
  logic                   abort;
  logic                   ovf_set;

  // Stage 0 samples the asynchronous ack; each later stage copies its neighbour.
  assign sync_d[0] = bus.i_async_ack;
  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_d[gi] = sync_q[gi-1];
    end
  endgenerate
  assign ack_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    done_d  = 1'b0;
    tcnt_d  = tcnt_q;
    launch  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_d = 1'b0;
        // A still-high ack from a previous exchange must fall before relaunch.
        if ((pending_q != '0) && !ack_s) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          launch  = 1'b1;
          tcnt_d  = '0;
        end
      end
      ST_REQ: begin
        tcnt_d = tcnt_q + 1'b1;
        if (ack_s) begin
          state_d = ST_WAIT_LOW;
          req_d   = 1'b0;
        end else if (TO_EN && (tcnt_q == TO_LIM)) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          abort   = 1'b1;
        end
      end
      ST_WAIT_LOW: begin
        tcnt_d = tcnt_q + 1'b1;
        req_d  = 1'b0;
        // Handshake progress takes priority over an abort on the same edge.
        if (!ack_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (TO_EN && (tcnt_q == TO_LIM)) begin
          state_d = ST_IDLE;
          abort   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    ovf_set   = 1'b0;
    if (bus.i_pulse && !launch) begin
      if (pending_q == PEND_MAX) begin
        ovf_set = 1'b1;
      end else begin
        pending_d = pending_q + 1'b1;
      end
    end else if (!bus.i_pulse && launch) begin
      pending_d = pending_q - 1'b1;
    end
    // A set condition wins over a clear arriving on the same edge.
    overflow_d = ovf_set | (overflow_q & ~bus.i_clear_err);
    timeout_d  = abort   | (timeout_q  & ~bus.i_clear_err);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      sync_q     <= '0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      req_q      <= req_d;
      done_q     <= done_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign bus.o_req      = req_q;
  assign bus.o_done     = done_q;
  assign bus.o_pending  = pending_q;
  assign bus.o_overflow = overflow_q;
  assign bus.o_timeout  = timeout_q;
  assign bus.o_busy     = (state_q != ST_IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_space_wire_pulse_handshake_tx.sv
// Bench for the pulse handshake transmitter: a far-side responder with random
// echo delays, a transaction-level reference model and per-cycle comparison.
module tb_space_wire_pulse_handshake_tx;

  localparam int SS   = 2;
  localparam int CW   = 3;
  localparam int TO   = 16;
  localparam int PMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  space_wire_pulse_handshake_tx_if #(.CNT_WIDTH(CW)) bus ();

  space_wire_pulse_handshake_tx #(
    .SYNC_STAGES    (SS),
    .CNT_WIDTH      (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: an exchange is "in flight" from launch until the far
  // side's ack has been seen to rise and fall, or until it has aged TO edges.
  int  m_pend = 0;
  bit  m_fly = 0, m_acked = 0, m_done = 0, m_ovf = 0, m_tout = 0;
  int  m_age = 0;
  bit  hist[SS];
  int  cyc = 0;

  always @(posedge clk) begin
    bit seen, launch, ab, p, c, a;
    p = bus.i_pulse;
    c = bus.i_clear_err;
    a = bus.i_async_ack;
    cyc++;
    if (rst) begin
      m_pend = 0; m_fly = 0; m_acked = 0; m_done = 0;
      m_ovf = 0; m_tout = 0; m_age = 0;
      for (int i = 0; i < SS; i++) hist[i] = 1'b0;
    end else begin
      seen = hist[SS-1];
      launch = 1'b0;
      ab = 1'b0;
      m_done = 1'b0;
      if (!m_fly) begin
        if (m_pend > 0 && !seen) begin
          launch = 1'b1; m_fly = 1'b1; m_acked = 1'b0; m_age = 0;
        end
      end else begin
        m_age++;
        if (!m_acked && seen) m_acked = 1'b1;
        else if (m_acked && !seen) begin m_fly = 1'b0; m_done = 1'b1; end
        else if (m_age == TO) begin m_fly = 1'b0; ab = 1'b1; end
      end
      m_ovf  = (p && !launch && m_pend == PMAX) || (m_ovf && !c);
      m_tout = ab || (m_tout && !c);
      if (p && !launch && m_pend < PMAX) m_pend++;
      else if (!p && launch) m_pend--;
      for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = a;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("req",      bus.o_req,      int'(m_fly && !m_acked));
      check("done",     bus.o_done,     int'(m_done));
      check("pending",  bus.o_pending,  m_pend);
      check("overflow", bus.o_overflow, int'(m_ovf));
      check("timeout",  bus.o_timeout,  int'(m_tout));
      check("busy",     bus.o_busy,     int'(m_fly || m_pend != 0));
    end
  end

  // Far-side responder: follows o_req after a random delay; can refuse to ack
  // (r_never) or have its ack level overridden (r_force).
  logic r_req = 1'b0;
  int   r_dly = 0;
  int   r_min = 0, r_max = 0;
  bit   r_never = 0, r_force = 0, r_fval = 0;

  task automatic resp_step();
    if (bus.o_req !== r_req) begin
      r_req = bus.o_req;
      r_dly = (r_never && r_req) ? -1 : int'($urandom_range(r_max, r_min));
    end else if (r_dly > 0) begin
      r_dly--;
    end
    if (r_dly == 0) bus.i_async_ack = r_req;
    if (r_force) bus.i_async_ack = r_fval;
  endtask

  // Waits for the falling edge, then sets the inputs for the next rising edge.
  task automatic drive(input bit p, input bit c);
    @(negedge clk);
    resp_step();
    bus.i_pulse     = p;
    bus.i_clear_err = c;
  endtask

  int  n_done, peak, run, first_hi, relaunch;
  bit  got;
  bit  samp[64];

  initial begin
    bus.i_pulse = 1'b0;
    bus.i_async_ack = 1'b0;
    bus.i_clear_err = 1'b0;
    rst = 1'b1;
    repeat (3) drive(0, 0);
    check("rst_req", bus.o_req, 0);
    check("rst_pending", bus.o_pending, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_flags", {bus.o_overflow, bus.o_timeout, bus.o_done}, 0);
    rst = 1'b0;
    drive(0, 0);

    // Single event with an instantly echoing far side.
    r_min = 0; r_max = 0;
    drive(1, 0);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      drive(0, 0);
      if (n == 0) begin
        check("t1_pend_first", bus.o_pending, 1);
        check("t1_req_first", bus.o_req, 0);
      end
      if (n == 1) begin
        check("t1_req_second", bus.o_req, 1);
        check("t1_pend_second", bus.o_pending, 0);
      end
      if (bus.o_done) begin
        got = 1'b1;
        check("t1_done_edge", n, 7);
        check("t1_busy_after", bus.o_busy, 0);
      end
    end
    check("t1_done_seen", got, 1);

    // Five consecutive pulses against a slow far side.
    r_min = 4; r_max = 4;
    n_done = 0; peak = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0);
      if (int'(bus.o_pending) > peak) peak = bus.o_pending;
    end
    for (int n = 0; n < 200; n++) begin
      drive(0, 0);
      if (int'(bus.o_pending) > peak) peak = bus.o_pending;
      if (bus.o_done) n_done++;
    end
    check("t2_peak", peak, 4);
    check("t2_dones", n_done, 5);
    check("t2_overflow", bus.o_overflow, 0);

    // Saturate the counter while the ack is held low, then drain and clear.
    r_min = 0; r_max = 0; r_force = 1; r_fval = 0;
    for (int i = 0; i < 9; i++) begin
      drive(1, 0);
      if (i == 2) begin
        check("t4_pend_on_launch", bus.o_pending, 1);
        check("t4_no_overflow", bus.o_overflow, 0);
      end
    end
    drive(0, 0);
    check("t3_pend_sat", bus.o_pending, PMAX);
    check("t3_overflow", bus.o_overflow, 1);
    r_force = 0;
    n_done = 0;
    for (int n = 0; n < 300; n++) begin
      drive(0, 0);
      if (bus.o_done) n_done++;
    end
    check("t3_dones", n_done, PMAX + 1);
    check("t3_no_timeout", bus.o_timeout, 0);
    drive(0, 1);
    drive(0, 0);
    check("t3_cleared", bus.o_overflow, 0);

    // Far side never acknowledges: the exchange is aborted after TO cycles.
    r_never = 1;
    drive(1, 0);
    drive(1, 0);
    for (int n = 0; n < 64; n++) begin
      drive(0, 0);
      samp[n] = bus.o_req;
      if (bus.o_done) check("t5_no_done", 1, 0);
    end
    run = 0; first_hi = -1; relaunch = 0;
    for (int n = 0; n < 64; n++) begin
      if (first_hi < 0 && samp[n]) first_hi = n;
      if (first_hi >= 0 && n >= first_hi && samp[n] && run == n - first_hi) run++;
      if (first_hi >= 0 && n > first_hi + run && samp[n]) relaunch = 1;
    end
    check("t5_req_high_len", run, TO);
    check("t5_relaunch", relaunch, 1);
    check("t5_timeout", bus.o_timeout, 1);
    r_never = 0;
    repeat (40) drive(0, 0);
    drive(0, 1);
    drive(0, 0);
    check("t5_cleared", bus.o_timeout, 0);

    // Reset during REQ with two events queued; a stale ack must block launch.
    r_force = 1; r_fval = 0;
    repeat (3) drive(1, 0);
    drive(0, 0);
    check("t6_req_before", bus.o_req, 1);
    check("t6_pend_before", bus.o_pending, 2);
    r_fval = 1;
    rst = 1'b1;
    drive(0, 0);
    rst = 1'b0;
    check("t6_req_after", bus.o_req, 0);
    check("t6_pend_after", bus.o_pending, 0);
    check("t6_busy_after", bus.o_busy, 0);
    repeat (3) drive(0, 0);
    drive(1, 0);
    got = 1'b0;
    for (int n = 0; n < 6; n++) begin
      drive(0, 0);
      if (bus.o_req) got = 1'b1;
    end
    check("t6_stale_blocks", got, 0);
    r_force = 0;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      drive(0, 0);
      if (bus.o_req) got = 1'b1;
    end
    check("t6_launch_after_fall", got, 1);
    repeat (40) drive(0, 0);

    // Randomized traffic with varying far-side behaviour.
    for (int blk = 0; blk < 15; blk++) begin
      int dens;
      r_min   = $urandom_range(2, 0);
      r_max   = r_min + $urandom_range(9, 0);
      r_never = ($urandom_range(7, 0) == 0);
      dens    = $urandom_range(6, 1);
      for (int n = 0; n < 200; n++) begin
        if ($urandom_range(499, 0) == 0) begin
          rst = 1'b1;
          drive(0, 0);
          rst = 1'b0;
        end else begin
          drive($urandom_range(dens * 4, 0) == 0, $urandom_range(15, 0) == 0);
        end
      end
    end
    drive(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
